// File: rtl/wb_ctrl_pkg.sv
// Shared constants and types for the write-back controller.
`ifndef DATA_BUS
`define DATA_BUS 64
`endif
`ifndef ZERO_64
`define ZERO_64 64'h0
`endif
`ifndef WB_DEPTH_DEF
`define WB_DEPTH_DEF 4
`endif

package wb_ctrl_pkg;

  localparam int unsigned DATA_W       = `DATA_BUS;
  localparam int unsigned RD_W         = 5;
  localparam int unsigned NREG         = 32;
  localparam int unsigned WB_DEPTH_DEF = `WB_DEPTH_DEF;

  localparam logic [DATA_W-1:0] ZERO_DATA = `ZERO_64;

  // One queued register-file write.
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which source wins when both are offering.
  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } pri_e;

endpackage

// File: rtl/wb_fifo.sv
// Write-back queue: FIFO of {rd, data} with per-entry valid/rd exposed.
module wb_fifo
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output wb_entry_t                   head,
  output logic [DEPTH-1:0]            valid,
  output logic [DEPTH-1:0][RD_W-1:0]  rds
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Pointers, occupancy and entry valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        wptr        <= wptr + AW'(1);
        valid[wptr] <= 1'b1;
      end
      if (pop) begin
        rptr        <= rptr + AW'(1);
        valid[rptr] <= 1'b0;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Entry payload storage; qualified by valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= push_entry;
    end
  end

  // Per-entry destination view for the pending scoreboard.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rds[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: round-robin ALU/LSU arbitration into a queue
// that drains one entry per cycle to the register file.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_i,
  input  logic [4:0]        alu_rd_i,
  input  logic [63:0]       alu_data_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [4:0]        lsu_rd_i,
  input  logic [63:0]       lsu_data_i,
  output logic              lsu_ready_o,
  input  logic              wb_stall_i,
  output logic              WriteEnable,
  output logic [4:0]        WriteAddr,
  output logic [63:0]       WriteData,
  output logic [31:0]       pending_o
);

  pri_e                          pri_q;
  pri_e                          pri_d;
  logic                          grant_alu;
  logic                          grant_lsu;
  logic                          alu_xfer;
  logic                          lsu_xfer;
  logic                          push;
  logic                          pop;
  wb_entry_t                     push_entry;
  logic                          full;
  logic                          empty;
  wb_entry_t                     head;
  logic [WB_DEPTH-1:0]           fifo_valid;
  logic [WB_DEPTH-1:0][RD_W-1:0] fifo_rds;

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pri_q <= PRI_ALU;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Hand priority to the other source after a contended grant.
  always_comb begin
    pri_d = pri_q;
    if (alu_valid_i && lsu_valid_i && !full) begin
      pri_d = (pri_q == PRI_ALU) ? PRI_LSU : PRI_ALU;
    end
  end

  // Grant decode: a lone requester wins, otherwise the priority holder.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (alu_valid_i && (!lsu_valid_i || pri_q == PRI_ALU)) begin
      grant_alu = 1'b1;
    end else if (lsu_valid_i) begin
      grant_lsu = 1'b1;
    end
  end

  // Ready is held low during reset and whenever the queue is full.
  assign alu_ready_o = rst & grant_alu & ~full;
  assign lsu_ready_o = rst & grant_lsu & ~full;
  assign alu_xfer    = alu_valid_i & alu_ready_o;
  assign lsu_xfer    = lsu_valid_i & lsu_ready_o;

  // Writes to x0 complete the handshake but never enter the queue.
  always_comb begin
    push       = 1'b0;
    push_entry = '{rd: lsu_rd_i, data: lsu_data_i};
    if (alu_xfer) begin
      push       = (alu_rd_i != '0);
      push_entry = '{rd: alu_rd_i, data: alu_data_i};
    end else if (lsu_xfer) begin
      push       = (lsu_rd_i != '0);
    end
  end

  assign pop = ~empty & ~wb_stall_i;

  wb_fifo #(
    .DEPTH (WB_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .valid      (fifo_valid),
    .rds        (fifo_rds)
  );

  // Register-file write port, driven straight from the queue head.
  always_comb begin
    WriteEnable = pop;
    WriteAddr   = pop ? head.rd : '0;
    WriteData   = pop ? head.data : ZERO_DATA;
  end

  // Pending scoreboard over live queue entries; x0 is never pending.
  always_comb begin
    pending_o = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (fifo_valid[i]) begin
        pending_o[fifo_rds[i]] = 1'b1;
      end
    end
    pending_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl against a queue-based reference model.
module tb_wb_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [63:0] alu_data_i;
  logic        alu_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [63:0] lsu_data_i;
  logic        lsu_ready_o;
  logic        wb_stall_i;
  logic        WriteEnable;
  logic [4:0]  WriteAddr;
  logic [63:0] WriteData;
  logic [31:0] pending_o;

  wb_ctrl #(.WB_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .alu_ready_o (alu_ready_o),
    .lsu_valid_i (lsu_valid_i),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_data_i  (lsu_data_i),
    .lsu_ready_o (lsu_ready_o),
    .wb_stall_i  (wb_stall_i),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .pending_o   (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ref_entry_t;

  ref_entry_t ref_q[$];
  int         ref_pri_lsu;  // 0: ALU holds priority, 1: LSU holds it
  int         n_vec  = 0;
  int         n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                       input logic st);
    alu_valid_i = av;  alu_rd_i = ard;  alu_data_i = ad;
    lsu_valid_i = lv;  lsu_rd_i = lrd;  lsu_data_i = ld;
    wb_stall_i  = st;
  endtask

  // One clock cycle: apply inputs, compare all outputs to the model, advance model.
  task automatic step(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                      input logic st);
    bit          q_full;
    bit          e_ar, e_lr, e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic [31:0] e_pend;
    @(negedge clk);
    drive(av, ard, ad, lv, lrd, ld, st);
    #1;
    q_full = (ref_q.size() == DEPTH);
    e_ar   = !q_full && av && (!lv || ref_pri_lsu == 0);
    e_lr   = !q_full && lv && (!av || ref_pri_lsu == 1);
    e_we   = (ref_q.size() != 0) && !st;
    e_wa   = e_we ? ref_q[0].rd : 5'd0;
    e_wd   = e_we ? ref_q[0].data : 64'd0;
    e_pend = '0;
    foreach (ref_q[i]) e_pend[ref_q[i].rd] = 1'b1;
    e_pend[0] = 1'b0;
    chk("alu_ready", 64'(alu_ready_o), 64'(e_ar));
    chk("lsu_ready", 64'(lsu_ready_o), 64'(e_lr));
    chk("write_en",  64'(WriteEnable), 64'(e_we));
    chk("write_addr", 64'(WriteAddr),  64'(e_wa));
    chk("write_data", WriteData,       e_wd);
    chk("pending",   64'(pending_o),   64'(e_pend));
    if (e_we) void'(ref_q.pop_front());
    if (e_ar && ard != 0) ref_q.push_back('{rd: ard, data: ad});
    if (e_lr && lrd != 0) ref_q.push_back('{rd: lrd, data: ld});
    if (av && lv && !q_full) ref_pri_lsu = 1 - ref_pri_lsu;
  endtask

  task automatic idle(input logic st);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, st);
  endtask

  // Assert reset with live requests present; everything must read zero at once.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_alu_ready", 64'(alu_ready_o), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready_o), 64'd0);
    chk("rst_we",        64'(WriteEnable), 64'd0);
    chk("rst_wa",        64'(WriteAddr),   64'd0);
    chk("rst_wd",        WriteData,        64'd0);
    chk("rst_pending",   64'(pending_o),   64'd0);
    ref_q.delete();
    ref_pri_lsu = 0;
    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    ref_pri_lsu = 0;
    do_reset();

    // Single write, one-cycle latency.
    step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0);
    idle(1'b0);
    chk("single_we",   64'(WriteEnable), 64'd1);
    chk("single_wa",   64'(WriteAddr),   64'd5);
    chk("single_wd",   WriteData,        64'h1234);
    chk("single_pend", 64'(pending_o),   64'h20);
    idle(1'b0);

    // Contention: ALU first, then strict alternation.
    do_reset();
    step(1'b1, 5'd1, 64'hA, 1'b1, 5'd2, 64'hB, 1'b0);
    chk("cont_g0_alu", 64'(alu_ready_o), 64'd1);
    step(1'b1, 5'd1, 64'hA, 1'b1, 5'd2, 64'hB, 1'b0);
    chk("cont_g1_lsu", 64'(lsu_ready_o), 64'd1);
    chk("cont_w0_rd1", 64'(WriteAddr),   64'd1);
    step(1'b1, 5'd1, 64'hA, 1'b1, 5'd2, 64'hB, 1'b0);
    chk("cont_g2_alu", 64'(alu_ready_o), 64'd1);
    chk("cont_w1_rd2", 64'(WriteAddr),   64'd2);
    step(1'b1, 5'd1, 64'hA, 1'b1, 5'd2, 64'hB, 1'b0);
    chk("cont_g3_lsu", 64'(lsu_ready_o), 64'd1);
    repeat (2) idle(1'b0);

    // x0 discard.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF, 1'b0);
    chk("x0_ready", 64'(lsu_ready_o), 64'd1);
    idle(1'b0);
    chk("x0_no_we", 64'(WriteEnable), 64'd0);
    chk("x0_pend",  64'(pending_o),   64'd0);

    // Full queue under stall, then drain.
    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), 64'(i * 16), 1'b0, 5'd0, 64'd0, 1'b1);
    chk("full_block", 64'(alu_ready_o), 64'd0);
    chk("full_pend",  64'(pending_o),   64'h1E);
    repeat (3) step(1'b1, 5'd5, 64'h50, 1'b0, 5'd0, 64'd0, 1'b0);
    repeat (4) idle(1'b0);

    // Reset mid-operation discards queued work.
    for (int i = 1; i <= 3; i++) step(1'b1, 5'(i + 8), 64'(i), 1'b0, 5'd0, 64'd0, 1'b1);
    do_reset();
    idle(1'b0);
    chk("post_rst_no_we", 64'(WriteEnable), 64'd0);

    // Same-rd ordering hazard.
    step(1'b1, 5'd7, 64'd1, 1'b0, 5'd0, 64'd0, 1'b1);
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'd2, 1'b1);
    idle(1'b0);
    chk("haz_first",  WriteData, 64'd1);
    idle(1'b0);
    chk("haz_second", WriteData, 64'd2);
    chk("haz_pend7",  64'(pending_o[7]), 64'd1);
    idle(1'b0);
    chk("haz_clear",  64'(pending_o), 64'd0);

    // Randomized traffic with small rd range to provoke hazards and x0.
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
           1'($urandom_range(0, 3) == 0));
      if (n == 300) do_reset();
    end
    repeat (DEPTH + 1) idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
